// File: rtl/chain_pkg.sv
// rtl/chain_pkg.sv - shared types for the chain traceback; CHAIN_TB_DEPTH_EN adds a depth field
package chain_pkg;

  localparam int CHAIN_MAX_N = 32;
  localparam int CHAIN_IDX_W = 8;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_POP       = 3'd1;
  localparam logic [2:0] S_RDWAIT    = 3'd2;
  localparam logic [2:0] S_PUSH_SELF = 3'd3;
  localparam logic [2:0] S_PUSH_R    = 3'd4;
  localparam logic [2:0] S_PUSH_L    = 3'd5;
  localparam logic [2:0] S_EMIT      = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  typedef struct packed {
    logic [CHAIN_IDX_W-1:0] i;
    logic [CHAIN_IDX_W-1:0] j;
    logic [CHAIN_IDX_W-1:0] k;
    logic                   visited;
`ifdef CHAIN_TB_DEPTH_EN
    logic [CHAIN_IDX_W-1:0] depth;
`endif
  } stk_entry_t;

  typedef struct packed {
    logic [CHAIN_IDX_W-1:0] i;
    logic [CHAIN_IDX_W-1:0] k;
    logic [CHAIN_IDX_W-1:0] j;
  } op_t;

endpackage

// File: rtl/tb_stack.sv
// rtl/tb_stack.sv - synchronous LIFO with combinational top; only the pointer is reset
module tb_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_m1;

  assign sp_m1 = sp - 1'b1;
  assign full  = (sp == PW'(DEPTH));
  assign empty = (sp == '0);
  assign top   = mem[sp_m1[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[sp[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sp <= '0;
    else if (push && !full)  sp <= sp + 1'b1;
    else if (pop && !empty)  sp <= sp - 1'b1;
  end

  // The traceback FSM only pops after checking empty.
  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/chain_traceback.sv
// rtl/chain_traceback.sv - post-order walk of the split table; CHAIN_TB_DEPTH_EN adds op_depth
module chain_traceback
  import chain_pkg::*;
#(
  parameter int MAX_N     = CHAIN_MAX_N,
  parameter int IDX_W     = CHAIN_IDX_W,
  parameter int STK_DEPTH = 2 * MAX_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IDX_W-1:0] matlen,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_i,
  output logic [IDX_W-1:0] rd_j,
  input  logic [IDX_W-1:0] rd_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [IDX_W-1:0] op_i,
  output logic [IDX_W-1:0] op_k,
  output logic [IDX_W-1:0] op_j,
`ifdef CHAIN_TB_DEPTH_EN
  output logic [IDX_W-1:0] op_depth,
`endif
  output logic             busy,
  output logic             done,
  output logic             error
);

  logic [2:0]  state;
  stk_entry_t  cur;
  stk_entry_t  top;
  stk_entry_t  push_data;
  op_t         op_q;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        rd_fire;
  logic        start_ok;
`ifdef CHAIN_TB_DEPTH_EN
  logic [IDX_W-1:0] depth_q;
  assign op_depth = depth_q;
`endif

  tb_stack #(
    .W     ($bits(stk_entry_t)),
    .DEPTH (STK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_data),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  assign start_ok = start && (matlen > 1) && (matlen <= IDX_W'(MAX_N));
  assign rd_fire  = (state == S_POP) && !empty && !top.visited && (top.i != top.j);
  assign rd_en    = rd_fire;
  assign rd_i     = rd_fire ? top.i : '0;
  assign rd_j     = rd_fire ? top.j : '0;
  assign pop      = (state == S_POP) && !empty;
  assign push     = push_req && !full;
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign op_i     = op_q.i;
  assign op_k     = op_q.k;
  assign op_j     = op_q.j;

  always_comb begin
    push_req  = 1'b0;
    push_data = '0;
    case (state)
      S_IDLE, S_DONE: begin
        push_req    = start_ok;
        push_data.j = matlen - 1'b1;
      end
      S_PUSH_SELF: begin
        push_req          = 1'b1;
        push_data         = cur;
        push_data.visited = 1'b1;
      end
      S_PUSH_R: begin
        push_req    = 1'b1;
        push_data.i = cur.k + 1'b1;
        push_data.j = cur.j;
`ifdef CHAIN_TB_DEPTH_EN
        push_data.depth = cur.depth + 1'b1;
`endif
      end
      S_PUSH_L: begin
        push_req    = 1'b1;
        push_data.i = cur.i;
        push_data.j = cur.k;
`ifdef CHAIN_TB_DEPTH_EN
        push_data.depth = cur.depth + 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cur      <= '0;
      op_q     <= '0;
      op_valid <= 1'b0;
      error    <= 1'b0;
`ifdef CHAIN_TB_DEPTH_EN
      depth_q  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            error <= (matlen > IDX_W'(MAX_N));
            state <= start_ok ? S_POP : S_DONE;
          end
        end
        S_POP: begin
          if (empty) begin
            state <= S_DONE;
          end else if (top.i == top.j) begin
            state <= S_POP;
          end else if (!top.visited) begin
            cur   <= top;
            state <= S_RDWAIT;
          end else begin
            op_q     <= '{i: top.i, k: top.k, j: top.j};
            op_valid <= 1'b1;
`ifdef CHAIN_TB_DEPTH_EN
            depth_q  <= top.depth;
`endif
            state    <= S_EMIT;
          end
        end
        S_RDWAIT: begin
          if (rd_data < cur.i || rd_data >= cur.j) begin
            error <= 1'b1;
            state <= S_DONE;
          end else begin
            cur.k <= rd_data;
            state <= S_PUSH_SELF;
          end
        end
        S_PUSH_SELF, S_PUSH_R, S_PUSH_L: begin
          if (full) begin
            error <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= (state == S_PUSH_SELF) ? S_PUSH_R :
                     (state == S_PUSH_R)    ? S_PUSH_L : S_POP;
          end
        end
        S_EMIT: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= S_POP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chain_traceback.sv
// tb/tb_chain_traceback.sv - directed scoreboard bench for chain_traceback; honours CHAIN_TB_DEPTH_EN
module tb_chain_traceback;

  typedef struct {
    logic [7:0] i;
    logic [7:0] k;
    logic [7:0] j;
    logic [7:0] d;
  } exp_op_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] matlen = '0;
  logic       rd_en;
  logic [7:0] rd_i, rd_j;
  logic [7:0] rd_data = 8'hFF;
  logic       op_valid;
  logic       op_ready = 1'b1;
  logic [7:0] op_i, op_k, op_j;
  logic [7:0] op_depth;
  logic       busy, done, error;

  int tests = 0;
  int failed = 0;
  int rd_cnt = 0;
  int ops_seen = 0;
  exp_op_t q[$];

  logic [7:0] s [0:31][0:31];
  logic       pend = 1'b0;
  logic [7:0] pi, pj;

  always #5 clk = ~clk;

  chain_traceback dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .matlen   (matlen),
    .rd_en    (rd_en),
    .rd_i     (rd_i),
    .rd_j     (rd_j),
    .rd_data  (rd_data),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_i     (op_i),
    .op_k     (op_k),
    .op_j     (op_j),
`ifdef CHAIN_TB_DEPTH_EN
    .op_depth (op_depth),
`endif
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

`ifndef CHAIN_TB_DEPTH_EN
  assign op_depth = 8'h00;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Split-table responder: data appears only in the cycle after rd_en.
  always @(negedge clk) begin
    rd_data = pend ? s[pi[4:0]][pj[4:0]] : 8'hFF;
    pend = rd_en;
    pi = rd_i;
    pj = rd_j;
    if (rd_en) rd_cnt++;
  end

  // Every cycle op_valid is high, the presented op must equal the scoreboard head.
  always @(negedge clk) begin
    if (op_valid) begin
      if (q.size() == 0) begin
        check("unexpected_op", {8'h0, op_i, op_k, op_j}, 32'hFFFFFFFF);
      end else begin
        check("op_ikj", {8'h0, op_i, op_k, op_j}, {8'h0, q[0].i, q[0].k, q[0].j});
`ifdef CHAIN_TB_DEPTH_EN
        check("op_depth", {24'h0, op_depth}, {24'h0, q[0].d});
`endif
        if (op_ready) begin
          void'(q.pop_front());
          ops_seen++;
        end
      end
    end
  end

  function automatic exp_op_t mk(input int i, input int k, input int j, input int d);
    exp_op_t e;
    e.i = 8'(i); e.k = 8'(k); e.j = 8'(j); e.d = 8'(d);
    return e;
  endfunction

  task automatic pulse_start(input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    matlen = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, "_done"}, {31'h0, done}, 32'h1);
  endtask

  task automatic load_t1();
    s[0][2] = 8'd0; s[1][2] = 8'd1;
  endtask

  task automatic load_t2();
    s[0][3] = 8'd1; s[0][1] = 8'd0; s[2][3] = 8'd2;
  endtask

  task automatic push_t2();
    q.push_back(mk(0, 0, 1, 1));
    q.push_back(mk(2, 2, 3, 1));
    q.push_back(mk(0, 1, 3, 0));
  endtask

  initial begin
    int r0;
    int c;
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        s[a][b] = 8'hFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl", {27'h0, rd_en, op_valid, busy, done, error}, 32'h0);
    check("rst_idx", {rd_i, rd_j, op_i, op_k}, 32'h0);
    check("rst_opj", {24'h0, op_j}, 32'h0);
    rst_n = 1'b1;

    // N=3, right-heavy split
    load_t1();
    q.push_back(mk(1, 1, 2, 1));
    q.push_back(mk(0, 0, 2, 0));
    r0 = rd_cnt;
    pulse_start(8'd3);
    check("t1_busy", {31'h0, busy}, 32'h1);
    wait_done("t1", 200);
    check("t1_err", {31'h0, error}, 32'h0);
    check("t1_left", q.size(), 0);
    check("t1_reads", rd_cnt - r0, 2);

    // N=4, balanced split
    load_t2();
    push_t2();
    r0 = rd_cnt;
    pulse_start(8'd4);
    wait_done("t2", 300);
    check("t2_err", {31'h0, error}, 32'h0);
    check("t2_left", q.size(), 0);
    check("t2_reads", rd_cnt - r0, 3);

    // Degenerate lengths
    r0 = rd_cnt;
    pulse_start(8'd1);
    wait_done("n1", 1);
    check("n1_err", {31'h0, error}, 32'h0);
    pulse_start(8'd0);
    wait_done("n0", 1);
    check("n0_err", {31'h0, error}, 32'h0);
    check("n01_reads", rd_cnt - r0, 0);

    // Oversized chain
    pulse_start(8'd40);
    wait_done("big", 2);
    check("big_err", {31'h0, error}, 32'h1);
    check("big_reads", rd_cnt - r0, 0);

    // N=4 with 10-cycle stall on every op
    op_ready = 1'b0;
    push_t2();
    pulse_start(8'd4);
    for (int n = 0; n < 3; n++) begin
      c = 0;
      while (!op_valid && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
      check("stall_valid", {31'h0, op_valid}, 32'h1);
      repeat (10) @(posedge clk);
      #1;
      op_ready = 1'b1;
      @(posedge clk); #1;
      op_ready = 1'b0;
    end
    wait_done("stall", 100);
    check("stall_left", q.size(), 0);
    op_ready = 1'b1;

    // Out-of-range split value, then recovery
    s[0][2] = 8'd2;
    r0 = ops_seen;
    pulse_start(8'd3);
    wait_done("bad", 50);
    check("bad_err", {31'h0, error}, 32'h1);
    check("bad_ops", ops_seen - r0, 0);
    load_t1();
    q.push_back(mk(1, 1, 2, 1));
    q.push_back(mk(0, 0, 2, 0));
    pulse_start(8'd3);
    check("rec_err_clr", {30'h0, error, done}, 32'h0);
    wait_done("rec", 200);
    check("rec_err", {31'h0, error}, 32'h0);
    check("rec_left", q.size(), 0);

    // Asynchronous reset after the first op
    push_t2();
    r0 = ops_seen;
    pulse_start(8'd4);
    c = 0;
    while (ops_seen == r0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check("mid_first_op", ops_seen - r0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {27'h0, rd_en, op_valid, busy, done, error}, 32'h0);
    check("mid_rst_idx", {rd_i, rd_j, op_i, op_k}, 32'h0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_t2();
    pulse_start(8'd4);
    wait_done("rerun", 300);
    check("rerun_err", {31'h0, error}, 32'h0);
    check("rerun_left", q.size(), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/chain_traceback.md
Name: chain_traceback

Overview:
- Reader at the far end of the chain-multiplier DP table.
- After the iteration/cost engine has filled the split table s[i][j], this block walks it from the root (0, N-1) and emits the multiplication schedule in post-order, so both operands of every op are ready before the op issues.
- Feeds the downstream matrix-multiply sequencer through a valid/ready stream.

Parameters:
- MAX_N, 32: maximum chain length supported.
- IDX_W, 8: width of matrix indices; matches the matlen width.
- STK_DEPTH, 2*MAX_N: traceback stack entries.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins traceback; ignored unless idle or done
- matlen  in  IDX_W  chain length N; sampled on start
- rd_en  out  1  split-table read strobe
- rd_i  out  IDX_W  split-table row
- rd_j  out  IDX_W  split-table column
- rd_data  in  IDX_W  s[rd_i][rd_j]; valid exactly 1 cycle after rd_en
- op_valid  out  1  schedule entry valid
- op_ready  in  1  downstream accepts
- op_i  out  IDX_W  left operand spans A[op_i..op_k]
- op_k  out  IDX_W  split point
- op_j  out  IDX_W  right operand spans A[op_k+1..op_j]
- busy  out  1  traceback in progress
- done  out  1  high from completion until the next start
- error  out  1  sticky until the next start; bad split value or stack overflow

Behaviour:
- Reset values:
  - rd_en, op_valid, busy, done, error = 0.
  - rd_i, rd_j, op_i, op_k, op_j = 0.
  - FSM = IDLE; stack empty.
- Stack entry = {i, j, k, visited}.
- FSM states and transitions:
  - IDLE, on start:
    - If matlen <= 1: go to DONE (zero ops).
    - If matlen > MAX_N: go to DONE with error = 1.
    - Otherwise: push {0, N-1, -, 0} and go to POP.
  - POP:
    - Stack empty: go to DONE.
    - Pop top. If i == j: stay in POP (leaf, discard).
    - If visited = 0: assert rd_en for one cycle with rd_i = i, rd_j = j; go to RDWAIT.
    - If visited = 1: load op_i/op_k/op_j; go to EMIT.
  - RDWAIT: capture k = rd_data.
    - If k < i or k >= j: error = 1, go to DONE.
    - Otherwise go to PUSH_SELF.
  - PUSH_SELF: push {i, j, k, 1}. Go to PUSH_R.
  - PUSH_R: push {k+1, j, -, 0}. Go to PUSH_L.
  - PUSH_L: push {i, k, -, 0}. Go to POP.
  - EMIT: op_valid = 1; op_* held stable until op_valid && op_ready. Then op_valid drops next cycle and FSM goes to POP.
  - DONE: done = 1, busy = 0. start restarts the walk and clears done and error.
- busy = 1 in every state except IDLE and DONE.
- Handshake rules:
  - op_valid never deasserts without a transfer.
  - op_ready may be tied high.
  - Throughput is at most 1 op per 2 cycles (EMIT then POP).
- Ordering: left subtree, then right subtree, then node. Exactly N-1 ops for a valid table.
- Stack:
  - A push when full sets error = 1 and goes to DONE.
  - The pop-from-empty path is unreachable by construction; the stack asserts it.
- Arithmetic:
  - All index math is IDX_W unsigned.
  - k+1 cannot wrap because k < j <= MAX_N-1.
- start while busy is ignored.
- rst_n assertion at any point: immediate return to reset values. Stack pointer cleared; stack contents don't care.

Optional Feature:
- Macro CHAIN_TB_DEPTH_EN.
- When defined:
  - Stack entries carry a depth field (IDX_W bits); the root has depth 0 and children have parent depth + 1.
  - Extra output op_depth (IDX_W) is valid with op_valid; the downstream uses it to pick a scratch buffer.
- When undefined: no depth storage and no op_depth port. All other behaviour is identical.

Decomposition:
- Package chain_pkg:
  - IDX_W and MAX_N defaults.
  - FSM state enum.
  - Stack-entry struct {i, j, k, visited [, depth]}.
  - op struct {i, k, j}.
- Sub-module tb_stack: synchronous LIFO.
  - push, pop, full, empty.
  - Combinational top.
  - Async active-low reset on the pointer only.

Test Plan:
- matlen=3, s[0][2]=0, s[1][2]=1 -> ops (1,1,2) then (0,0,2); done=1, error=0.
- matlen=4, s[0][3]=1, s[0][1]=0, s[2][3]=2 -> ops (0,0,1), (2,2,3), (0,1,3). With CHAIN_TB_DEPTH_EN, op_depth = 1, 1, 0.
- matlen=1, then matlen=0 -> no rd_en, no op_valid; done within 2 cycles of start.
- matlen=4 with op_ready low for 10 cycles on each op -> op_* held stable while stalled; same 3 ops emitted in order; no duplicates.
- matlen=3 with s[0][2]=2 (out of range) -> error=1, done=1, zero ops. The next start with a valid table clears error.
- rst_n pulsed low mid-walk (after 1st op) -> all outputs return to reset values asynchronously. A new start re-emits the full schedule from the first op.
